ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/cpu_defs.sv | 51 +++++
 rtl/ex_stage_if.sv | 33 +++
 rtl/ex_div.sv | 104 ++++++++++
 rtl/ex_stage.sv | 112 +++++++++++
 tb/tb_ex_stage.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: shared definitions for the execute stage.
// Holds bus widths, ALU operation/class encodings, common constants,
// the divider FSM state type and a small absolute-value helper.
// No ports (package).
package cpu_defs;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int AluOpBus   = 8;
   localparam int AluSelBus  = 3;

   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;

   // result classes
   localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
   localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
   localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;
   localparam logic [AluSelBus-1:0] EXE_RES_DIV   = 3'b110;

   // operation codes
   localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'b0010_0111;
   localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [AluOpBus-1:0] EXE_ADD_OP  = 8'b0010_0000;
   localparam logic [AluOpBus-1:0] EXE_SUB_OP  = 8'b0010_0010;
   localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'b0010_1010;
   localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'b0001_1011;

   // divider iteration counter: 32 quotient bits, counted 0..31
   localparam logic [5:0] DivLastCnt = 6'd31;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_DONE = 2'b10
   } div_state_t;

   function automatic logic [RegBus-1:0] abs_word(input logic [RegBus-1:0] v);
      return v[RegBus-1] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs and EX/MEM outputs of the execute stage.
// master: pipeline side (drives operation, operands, annul; receives results)
// slave : execute stage
interface ex_stage_if;
   import cpu_defs::*;

   logic [AluOpBus-1:0]   ex_aluop;
   logic [AluSelBus-1:0]  ex_alusel;
   logic [RegBus-1:0]     ex_reg1;
   logic [RegBus-1:0]     ex_reg2;
   logic [RegAddrBus-1:0] ex_wd;
   logic                  ex_wreg;
   logic                  annul;

   logic [RegAddrBus-1:0] wd_o;
   logic                  wreg_o;
   logic [RegBus-1:0]     wdata_o;
   logic [RegBus-1:0]     hi_o;
   logic [RegBus-1:0]     lo_o;
   logic                  whilo_o;
   logic                  stallreq;

   modport master (
      output ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, annul,
      input  wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq
   );

   modport slave (
      input  ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, annul,
      output wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq
   );

endinterface

// File: rtl/ex_div.sv
// ex_div: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             divide requested this cycle (sampled in IDLE)
//   signed_div        1 = DIV (signed), 0 = DIVU
//   annul             abort; returns to IDLE
//   opdata1, opdata2  dividend, divisor
//   ready             high in DONE; results valid
//   result_q/result_r sign-corrected quotient / remainder
//
// state    | meaning
// DIV_IDLE | waiting for start; latches operands and result signs
// DIV_CALC | 32 shift/subtract iterations
// DIV_DONE | results valid for one cycle
module ex_div
   import cpu_defs::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_div,
   input  logic              annul,
   input  logic [RegBus-1:0] opdata1,
   input  logic [RegBus-1:0] opdata2,
   output logic              ready,
   output logic [RegBus-1:0] result_q,
   output logic [RegBus-1:0] result_r
);

   div_state_t        state, state_nxt;
   logic [5:0]        cnt;
   logic [RegBus-1:0] dvs;
   logic [RegBus-1:0] quot;   // holds the dividend, shifted out as quotient bits shift in
   logic [RegBus-1:0] rem;
   logic              neg_q, neg_r;
   logic [RegBus:0]   rem_sh, diff;

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (annul) begin
         state_nxt = DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: if (start) state_nxt = (opdata2 == ZeroWord) ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (cnt == DivLastCnt) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
         endcase
      end
   end

   always_comb begin
      ready = (state == DIV_DONE);
   end

   // rem_sh can exceed 32 bits; bit 32 of diff set means it was below the divisor
   assign rem_sh = {rem, quot[RegBus-1]};
   assign diff   = rem_sh - {1'b0, dvs};

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         dvs   <= ZeroWord;
         quot  <= ZeroWord;
         rem   <= ZeroWord;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == DIV_IDLE && start && !annul) begin
         cnt <= '0;
         if (opdata2 == ZeroWord) begin
            // divide by zero: raw all-ones quotient, dividend as remainder, no sign fix
            dvs   <= ZeroWord;
            quot  <= '1;
            rem   <= opdata1;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
         end else begin
            dvs   <= signed_div ? abs_word(opdata2) : opdata2;
            quot  <= signed_div ? abs_word(opdata1) : opdata1;
            rem   <= ZeroWord;
            neg_q <= signed_div & (opdata1[RegBus-1] ^ opdata2[RegBus-1]);
            neg_r <= signed_div & opdata1[RegBus-1];
         end
      end else if (state == DIV_CALC) begin
         cnt <= cnt + 6'd1;
         if (!diff[RegBus]) begin
            rem  <= diff[RegBus-1:0];
            quot <= {quot[RegBus-2:0], 1'b1};
         end else begin
            rem  <= rem_sh[RegBus-1:0];
            quot <= {quot[RegBus-2:0], 1'b0};
         end
      end
   end

   assign result_q = neg_q ? (~quot + 32'd1) : quot;
   assign result_r = neg_r ? (~rem + 32'd1)  : rem;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage. Logic, shift and arithmetic results are
// combinational; DIV/DIVU use the multi-cycle ex_div and stall the pipeline.
// Build option: define EX_DIV_EN to include the divider; without it the DIV
// class produces no writes and never stalls.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   ex        ex_stage_if.slave: ID/EX operation and operands, annul,
//             EX/MEM result (wd_o, wreg_o, wdata_o), HI/LO (hi_o, lo_o,
//             whilo_o), stallreq
module ex_stage
   import cpu_defs::*;
(
   input  logic    clk,
   input  logic    rst,
   ex_stage_if.slave ex
);

   logic [RegBus-1:0] logic_res, shift_res, arith_res;
   logic [4:0]        shamt;
   logic              div_class;
   logic              div_ready;
   logic              div_stall;
   logic [RegBus-1:0] div_q, div_r;

   assign shamt     = ex.ex_reg2[4:0];
   assign div_class = (ex.ex_alusel == EXE_RES_DIV);

   always_comb begin
      logic_res = ZeroWord;
      case (ex.ex_aluop)
         EXE_AND_OP: logic_res = ex.ex_reg1 & ex.ex_reg2;
         EXE_OR_OP:  logic_res = ex.ex_reg1 | ex.ex_reg2;
         EXE_XOR_OP: logic_res = ex.ex_reg1 ^ ex.ex_reg2;
         EXE_NOR_OP: logic_res = ~(ex.ex_reg1 | ex.ex_reg2);
         default:    logic_res = ZeroWord;
      endcase
   end

   always_comb begin
      shift_res = ZeroWord;
      case (ex.ex_aluop)
         EXE_SLL_OP: shift_res = ex.ex_reg1 << shamt;
         EXE_SRL_OP: shift_res = ex.ex_reg1 >> shamt;
         EXE_SRA_OP: shift_res = $signed(ex.ex_reg1) >>> shamt;
         default:    shift_res = ZeroWord;
      endcase
   end

   always_comb begin
      arith_res = ZeroWord;
      case (ex.ex_aluop)
         EXE_ADD_OP: arith_res = ex.ex_reg1 + ex.ex_reg2;
         EXE_SUB_OP: arith_res = ex.ex_reg1 - ex.ex_reg2;
         EXE_SLT_OP: arith_res = {31'd0, ($signed(ex.ex_reg1) < $signed(ex.ex_reg2))};
         default:    arith_res = ZeroWord;
      endcase
   end

`ifdef EX_DIV_EN
   ex_div u_div (
      .clk        (clk),
      .rst        (rst),
      .start      (div_class && !ex.annul),
      .signed_div (ex.ex_aluop == EXE_DIV_OP),
      .annul      (ex.annul),
      .opdata1    (ex.ex_reg1),
      .opdata2    (ex.ex_reg2),
      .ready      (div_ready),
      .result_q   (div_q),
      .result_r   (div_r)
   );
   // stall from operand capture until the DONE cycle; annul drops it at once
   assign div_stall = div_class && !div_ready && !ex.annul;
`else
   logic div_unused;
   assign div_unused = clk;
   assign div_ready  = 1'b0;
   assign div_q      = ZeroWord;
   assign div_r      = ZeroWord;
   assign div_stall  = 1'b0;
`endif

   always_comb begin
      ex.wd_o     = NOPRegAddr;
      ex.wreg_o   = WriteDisable;
      ex.wdata_o  = ZeroWord;
      ex.hi_o     = ZeroWord;
      ex.lo_o     = ZeroWord;
      ex.whilo_o  = WriteDisable;
      ex.stallreq = 1'b0;
      if (!rst) begin
         ex.wd_o = ex.ex_wd;
         case (ex.ex_alusel)
            EXE_RES_LOGIC: ex.wdata_o = logic_res;
            EXE_RES_SHIFT: ex.wdata_o = shift_res;
            EXE_RES_ARITH: ex.wdata_o = arith_res;
            default:       ex.wdata_o = ZeroWord;
         endcase
         if (div_class) begin
            ex.stallreq = div_stall;
            if (div_ready) begin
               ex.lo_o    = div_q;
               ex.hi_o    = div_r;
               ex.whilo_o = !ex.annul;
            end
         end else begin
            ex.wreg_o = ex.annul ? WriteDisable : ex.ex_wreg;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
   import cpu_defs::*;

`ifdef EX_DIV_EN
   localparam bit DivOn = 1'b1;
`else
   localparam bit DivOn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_stage_if bus();
   ex_stage u_dut (.clk(clk), .rst(rst), .ex(bus));

   int errors = 0;
   int checks = 0;

   logic [2:0] t_sel [12] = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC,
                              EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_SHIFT,
                              EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH,
                              EXE_RES_NOP, 3'b111};
   logic [7:0] t_op  [12] = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP,
                              EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
                              EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP,
                              EXE_AND_OP, EXE_ADD_OP};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, t;
      int sh;
      sa = $signed(a);
      sb = $signed(b);
      sh = int'(b % 32);
      ref_alu = 32'd0;
      if (sel == EXE_RES_LOGIC) begin
         if (op == EXE_AND_OP) ref_alu = a & b;
         if (op == EXE_OR_OP)  ref_alu = a | b;
         if (op == EXE_XOR_OP) ref_alu = a ^ b;
         if (op == EXE_NOR_OP) ref_alu = 32'hFFFF_FFFF - (a | b);
      end else if (sel == EXE_RES_SHIFT) begin
         if (op == EXE_SLL_OP) ref_alu = 32'(longint'(a) * (longint'(1) << sh));
         if (op == EXE_SRL_OP) ref_alu = 32'(longint'(a) / (longint'(1) << sh));
         if (op == EXE_SRA_OP) begin
            // floor division of the signed value by 2^sh
            t = sa / (longint'(1) << sh);
            if (sa < 0 && (sa % (longint'(1) << sh)) != 0) t = t - 1;
            ref_alu = 32'(t);
         end
      end else if (sel == EXE_RES_ARITH) begin
         if (op == EXE_ADD_OP) ref_alu = 32'(longint'(a) + longint'(b));
         if (op == EXE_SUB_OP) ref_alu = 32'(longint'(a) - longint'(b));
         if (op == EXE_SLT_OP) ref_alu = (sa < sb) ? 32'd1 : 32'd0;
      end
   endfunction

   task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      if (!DivOn) begin
         q = 32'd0;
         r = 32'd0;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wreg);
      bus.ex_alusel = sel;
      bus.ex_aluop  = op;
      bus.ex_reg1   = a;
      bus.ex_reg2   = b;
      bus.ex_wd     = wd;
      bus.ex_wreg   = wreg;
   endtask

   // presents a divide and waits for the first non-stall cycle; samples it
   task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output bit done,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic whilo, output logic wreg);
      drive(EXE_RES_DIV, sgn ? EXE_DIV_OP : EXE_DIVU_OP, a, b, 5'd9, 1'b1);
      bus.annul = 1'b0;
      stalls = 0;
      done   = 1'b0;
      hi = 32'd0; lo = 32'd0; whilo = 1'b0; wreg = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.stallreq !== 1'b1) begin
            done  = 1'b1;
            hi    = bus.hi_o;
            lo    = bus.lo_o;
            whilo = bus.whilo_o;
            wreg  = bus.wreg_o;
            break;
         end
         stalls++;
         step();
      end
      step();
      drive(EXE_RES_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   function automatic int exp_stalls(input logic [31:0] b);
      if (!DivOn) return 0;
      return (b == 32'd0) ? 1 : 33;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.annul = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive(EXE_RES_ARITH, EXE_ADD_OP, 32'd5, 32'd6, 5'd3, 1'b1);
         else        drive(EXE_RES_DIV, EXE_DIV_OP, 32'd40, 32'd3, 5'd4, 1'b1);
         step();
         @(negedge clk);
         checks++; if (bus.wd_o !== 5'd0)      begin errors++; $display("FAIL reset_wd: got %h expected 0", bus.wd_o); end
         checks++; if (bus.wreg_o !== 1'b0)    begin errors++; $display("FAIL reset_wreg: got %b expected 0", bus.wreg_o); end
         checks++; if (bus.wdata_o !== 32'd0)  begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.wdata_o); end
         checks++; if (bus.hi_o !== 32'd0)     begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi_o); end
         checks++; if (bus.lo_o !== 32'd0)     begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo_o); end
         checks++; if (bus.whilo_o !== 1'b0)   begin errors++; $display("FAIL reset_whilo: got %b expected 0", bus.whilo_o); end
         checks++; if (bus.stallreq !== 1'b0)  begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stallreq); end
      end
      step();
      drive(EXE_RES_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_directed_alu();
      drive(EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFF_FFFF, 32'd1, 5'd7, 1'b1);
      @(negedge clk);
      checks++; if (bus.wdata_o !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf: got %h expected 80000000", bus.wdata_o); end
      checks++; if (bus.wreg_o !== 1'b1)   begin errors++; $display("FAIL add_wreg: got %b expected 1", bus.wreg_o); end
      checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL add_stall: got %b expected 0", bus.stallreq); end
      checks++; if (bus.wd_o !== 5'd7)     begin errors++; $display("FAIL add_wd: got %h expected 07", bus.wd_o); end
      step();
      drive(EXE_RES_SHIFT, EXE_SRA_OP, 32'h8000_0000, 32'd4, 5'd2, 1'b1);
      @(negedge clk);
      checks++; if (bus.wdata_o !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h expected f8000000", bus.wdata_o); end
      step();
      drive(EXE_RES_ARITH, EXE_SLT_OP, 32'hFFFF_FFFF, 32'd1, 5'd2, 1'b1);
      @(negedge clk);
      checks++; if (bus.wdata_o !== 32'd1) begin errors++; $display("FAIL slt: got %h expected 1", bus.wdata_o); end
      step();
   endtask

   task automatic test_random_alu();
      int idx;
      logic [31:0] a, b, exp_d;
      logic [4:0] wd;
      logic wr, an;
      for (int n = 0; n < 200; n++) begin
         idx = $urandom_range(0, 11);
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         wd = 5'($urandom);
         wr = 1'($urandom);
         an = ($urandom_range(0, 7) == 0);
         drive(t_sel[idx], t_op[idx], a, b, wd, wr);
         bus.annul = an;
         exp_d = ref_alu(t_sel[idx], t_op[idx], a, b);
         @(negedge clk);
         if (!an) begin
            checks++; if (bus.wdata_o !== exp_d) begin errors++; $display("FAIL rand_wdata: sel=%0d op=%h a=%h b=%h got %h expected %h", t_sel[idx], t_op[idx], a, b, bus.wdata_o, exp_d); end
         end
         checks++; if (bus.wreg_o !== (wr & !an)) begin errors++; $display("FAIL rand_wreg: got %b expected %b", bus.wreg_o, wr & !an); end
         checks++; if (bus.wd_o !== wd)        begin errors++; $display("FAIL rand_wd: got %h expected %h", bus.wd_o, wd); end
         checks++; if (bus.stallreq !== 1'b0)  begin errors++; $display("FAIL rand_stall: got %b expected 0", bus.stallreq); end
         checks++; if (bus.whilo_o !== 1'b0)   begin errors++; $display("FAIL rand_whilo: got %b expected 0", bus.whilo_o); end
         checks++; if ({bus.hi_o, bus.lo_o} !== 64'd0) begin errors++; $display("FAIL rand_hilo: got %h/%h expected 0/0", bus.hi_o, bus.lo_o); end
         step();
      end
      bus.annul = 1'b0;
   endtask

   task automatic test_div_signed();
      int st; bit dn; logic [31:0] hi, lo; logic wh, wr;
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, st, dn, hi, lo, wh, wr);
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL div_done: got %b expected 1", dn); end
      checks++; if (st != exp_stalls(32'd2)) begin errors++; $display("FAIL div_stalls: got %0d expected %0d", st, exp_stalls(32'd2)); end
      checks++; if (lo !== (DivOn ? 32'hFFFF_FFFD : 32'd0)) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
      checks++; if (hi !== (DivOn ? 32'hFFFF_FFFF : 32'd0)) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
      checks++; if (wh !== DivOn) begin errors++; $display("FAIL div_whilo: got %b expected %b", wh, DivOn); end
      checks++; if (wr !== 1'b0)  begin errors++; $display("FAIL div_wreg: got %b expected 0", wr); end
   endtask

   task automatic test_div_zero();
      int st; bit dn; logic [31:0] hi, lo; logic wh, wr;
      run_div(1'b0, 32'd7, 32'd0, st, dn, hi, lo, wh, wr);
      checks++; if (st != exp_stalls(32'd0)) begin errors++; $display("FAIL divz_stalls: got %0d expected %0d", st, exp_stalls(32'd0)); end
      checks++; if (lo !== (DivOn ? 32'hFFFF_FFFF : 32'd0)) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
      checks++; if (hi !== (DivOn ? 32'd7 : 32'd0)) begin errors++; $display("FAIL divz_hi: got %h expected 7", hi); end
      checks++; if (wh !== DivOn) begin errors++; $display("FAIL divz_whilo: got %b expected %b", wh, DivOn); end
   endtask

   task automatic test_annul();
      int st; bit dn; logic [31:0] hi, lo, eq, er; logic wh, wr;
      drive(EXE_RES_DIV, EXE_DIV_OP, 32'd1000, 32'd13, 5'd1, 1'b1);
      for (int i = 0; i < 9; i++) step();
      @(negedge clk);
      checks++; if (bus.stallreq !== DivOn) begin errors++; $display("FAIL annul_pre_stall: got %b expected %b", bus.stallreq, DivOn); end
      step();
      bus.annul = 1'b1;
      @(negedge clk);
      checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL annul_stall: got %b expected 0", bus.stallreq); end
      checks++; if (bus.whilo_o !== 1'b0)  begin errors++; $display("FAIL annul_whilo: got %b expected 0", bus.whilo_o); end
      checks++; if (bus.wreg_o !== 1'b0)   begin errors++; $display("FAIL annul_wreg: got %b expected 0", bus.wreg_o); end
      step();
      bus.annul = 1'b0;
      ref_div(1'b0, 32'd100, 32'd7, eq, er);
      run_div(1'b0, 32'd100, 32'd7, st, dn, hi, lo, wh, wr);
      checks++; if (st != exp_stalls(32'd7)) begin errors++; $display("FAIL annul_next_stalls: got %0d expected %0d", st, exp_stalls(32'd7)); end
      checks++; if (lo !== eq) begin errors++; $display("FAIL annul_next_lo: got %h expected %h", lo, eq); end
      checks++; if (hi !== er) begin errors++; $display("FAIL annul_next_hi: got %h expected %h", hi, er); end
   endtask

   task automatic test_reset_mid_div();
      int st; bit dn; logic [31:0] hi, lo, eq, er; logic wh, wr;
      drive(EXE_RES_DIV, EXE_DIVU_OP, $urandom, 32'($urandom_range(1, 1000)), 5'd6, 1'b1);
      for (int i = 0; i < 20; i++) step();
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({bus.wd_o, bus.wreg_o, bus.whilo_o, bus.stallreq} !== 8'd0) begin errors++; $display("FAIL rstmid_ctl: got wd=%h wreg=%b whilo=%b stall=%b expected all 0", bus.wd_o, bus.wreg_o, bus.whilo_o, bus.stallreq); end
      checks++; if ({bus.wdata_o, bus.hi_o, bus.lo_o} !== 96'd0) begin errors++; $display("FAIL rstmid_data: got %h/%h/%h expected 0", bus.wdata_o, bus.hi_o, bus.lo_o); end
      step();
      rst = 1'b0;
      ref_div(1'b0, 32'd9, 32'd3, eq, er);
      run_div(1'b0, 32'd9, 32'd3, st, dn, hi, lo, wh, wr);
      checks++; if (st != exp_stalls(32'd3)) begin errors++; $display("FAIL rstmid_stalls: got %0d expected %0d", st, exp_stalls(32'd3)); end
      checks++; if (lo !== eq) begin errors++; $display("FAIL rstmid_lo: got %h expected %h", lo, eq); end
      checks++; if (hi !== er) begin errors++; $display("FAIL rstmid_hi: got %h expected %h", hi, er); end
   endtask

   task automatic test_back_to_back();
      int st; bit dn; bit sgn; logic [31:0] a, b, hi, lo, eq, er; logic wh, wr;
      for (int n = 0; n < 8; n++) begin
         sgn = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         ref_div(sgn, a, b, eq, er);
         run_div(sgn, a, b, st, dn, hi, lo, wh, wr);
         checks++; if (st != exp_stalls(b)) begin errors++; $display("FAIL b2b_stalls: sgn=%b a=%h b=%h got %0d expected %0d", sgn, a, b, st, exp_stalls(b)); end
         checks++; if (lo !== eq) begin errors++; $display("FAIL b2b_lo: sgn=%b a=%h b=%h got %h expected %h", sgn, a, b, lo, eq); end
         checks++; if (hi !== er) begin errors++; $display("FAIL b2b_hi: sgn=%b a=%h b=%h got %h expected %h", sgn, a, b, hi, er); end
         checks++; if (wh !== DivOn) begin errors++; $display("FAIL b2b_whilo: got %b expected %b", wh, DivOn); end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.annul = 1'b0;
      drive(EXE_RES_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      step();
      test_reset();
      test_directed_alu();
      test_random_alu();
      test_div_signed();
      test_div_zero();
      test_annul();
      test_reset_mid_div();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
